rf_odp_monitor: RTL and testbench
=================================

RF_ODP_MONITOR -- requirements
Module: rf_odp_monitor

Interface
REQ-001 Parameter NUM_CH, default 4: number of RF channels monitored.
REQ-002 Parameter PWR_W, default 16: width of one unsigned instantaneous-power sample.
REQ-003 clk  input  1  single block clock; all logic is synchronous to its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 s_valid  input  1  one power sample per channel is present this cycle.
REQ-006 s_pwr  input  NUM_CH x PWR_W  unsigned per-channel instantaneous power (I^2+Q^2, pre-scaled).
REQ-007 rf_overdrive_thresh  input  32  window-sum alarm threshold, from register control.
REQ-008 rf_overdrive_avg_per  input  21  window length in valid samples; 0 disables windowing.
REQ-009 disable_rf_odp  input  NUM_CH  per-channel alarm disable, from register control.
REQ-010 odp_clear  input  1  single-cycle pulse that clears all latched alarms.
REQ-011 rf_overdrive_tssi  output  NUM_CH x 32  last completed window sum per channel, saturated; returned to register status.
REQ-012 odp_alarm  output  NUM_CH  latched per-channel overdrive alarm.
REQ-013 pa_shutdown  output  1  registered OR of odp_alarm; drives PA sleep logic.

Function
REQ-014 The block SHALL implement FSM states IDLE, ACCUM and EVAL.
REQ-015 IDLE: when rf_overdrive_avg_per != 0, the block SHALL capture it into win_len, zero all accumulators and the sample counter, and go to ACCUM.
REQ-016 ACCUM: on each s_valid, the block SHALL add each s_pwr lane to its 37-bit accumulator and increment the sample counter.
REQ-017 ACCUM: when the counter reaches win_len on an accepted sample (that sample included), the block SHALL go to EVAL.
REQ-018 EVAL lasts one cycle; a sample with s_valid in EVAL SHALL be dropped and not counted.
REQ-019 EVAL: per channel, rf_overdrive_tssi SHALL load min(acc, 2^32-1).
REQ-020 EVAL: per channel, the alarm SHALL set if saturated sum >= rf_overdrive_thresh and disable_rf_odp is 0.
REQ-021 EVAL SHALL then return to IDLE, so a new window starts on the next cycle if avg_per != 0.
REQ-022 Latency: tssi and odp_alarm SHALL update one cycle after the window-completing sample; pa_shutdown SHALL update one cycle later.
REQ-023 A change to rf_overdrive_avg_per mid-window SHALL take effect only at the next window start.
REQ-024 If rf_overdrive_avg_per becomes 0 mid-window, the current window SHALL complete with the captured win_len; the block then idles.
REQ-025 odp_alarm[i] is sticky and SHALL clear only on odp_clear, on disable_rf_odp[i]=1, or on reset.
REQ-026 When odp_clear and an alarm set coincide in one cycle, the set SHALL win.
REQ-027 While disable_rf_odp[i]=1, odp_alarm[i] SHALL be held at 0; rf_overdrive_tssi[i] SHALL still update.
REQ-028 A threshold of 0 with avg_per != 0 SHALL raise an alarm at every window end for each enabled channel.
REQ-029 The accumulator width (PWR_W + 21) SHALL never overflow, so the sum is exact before saturation.

Reset
REQ-030 On rst_n low, the block SHALL enter IDLE and clear accumulators, the counter and win_len to 0.
REQ-031 On rst_n low, rf_overdrive_tssi, odp_alarm and pa_shutdown SHALL go to 0.
REQ-032 Reset asserted mid-window SHALL discard the partial window with no tssi or alarm update.

Structure
REQ-033 A shared package SHALL hold NUM_CH, PWR_W, AVG_PER_W=21, TSSI_W=32, ACC_W=PWR_W+AVG_PER_W and the FSM state enum.
REQ-034 Sub-module rf_odp_chan SHALL contain one channel's accumulator, saturation, threshold compare and sticky alarm, instantiated NUM_CH times.
REQ-035 The window counter and FSM SHALL be shared by all channels in the top level.

Verification
REQ-036 avg_per=4, thresh=1000, s_pwr ch0=300 for 4 valid cycles -> tssi[0]=1200, odp_alarm[0]=1 one cycle after the 4th sample, pa_shutdown=1 one cycle later.
REQ-037 Same stimulus with disable_rf_odp[0]=1 -> tssi[0]=1200, odp_alarm[0]=0, pa_shutdown=0.
REQ-038 avg_per=2^21-1, all samples 0xFFFF -> tssi=0xFFFFFFFF (saturated), alarm set for thresh=0xFFFFFFFF.
REQ-039 Alarm latched, then odp_clear pulses in the same cycle as a new EVAL exceeding thresh -> alarm remains 1; a later clear with a below-threshold window -> alarm 0.
REQ-040 avg_per changed 4->8 after sample 2 -> first window closes after 4 samples, the next after 8; rst_n pulsed at sample 3 of a window -> tssi stays 0 and no alarm.
REQ-041 s_valid held high through EVAL with avg_per=3 -> every 4th sample is dropped; window sums match a reference model.

Source files
------------

// File: rtl/rf_odp_monitor_pkg.sv
// Shared widths and FSM state type for the RF overdrive-protection monitor.
package rf_odp_monitor_pkg;

    localparam int NUM_CH    = 4;
    localparam int PWR_W     = 16;
    localparam int AVG_PER_W = 21;
    localparam int TSSI_W    = 32;
    localparam int ACC_W     = PWR_W + AVG_PER_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EVAL  = 2'd2
    } odpState_e;

endpackage

// File: rtl/rf_odp_chan.sv
// One channel: window accumulator, saturation to the status width,
// threshold compare and the sticky overdrive alarm.
module rf_odp_chan
    import rf_odp_monitor_pkg::*;
#(
    parameter int PWR_W = rf_odp_monitor_pkg::PWR_W,
    parameter int ACC_W = rf_odp_monitor_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              accept_i,
    input  logic [PWR_W-1:0]  pwr_i,
    input  logic              eval_i,
    input  logic [TSSI_W-1:0] thresh_i,
    input  logic              disable_i,
    input  logic              clear_i,
    output logic [TSSI_W-1:0] tssi_o,
    output logic              alarm_o
);

    localparam logic [ACC_W-1:0] SatMax = {{(ACC_W-TSSI_W){1'b0}}, {TSSI_W{1'b1}}};

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [TSSI_W-1:0] tssi_q, tssi_d;
    logic              alarm_q, alarm_d;
    logic [TSSI_W-1:0] satSum;
    logic              setAlarm;

    assign satSum   = (acc_q > SatMax) ? '1 : acc_q[TSSI_W-1:0];
    assign setAlarm = eval_i && (satSum >= thresh_i);

    // A window start overwrites the previous sum, so the first sample
    // of a window can arrive on the very cycle the window opens.
    always_comb begin
        acc_d   = acc_q;
        tssi_d  = tssi_q;
        alarm_d = alarm_q;
        if (start_i) begin
            acc_d = accept_i ? ACC_W'(pwr_i) : '0;
        end else if (accept_i) begin
            acc_d = acc_q + ACC_W'(pwr_i);
        end
        if (eval_i) begin
            tssi_d = satSum;
        end
        // Disable forces the alarm low; a fresh set beats a clear pulse.
        if (disable_i) begin
            alarm_d = 1'b0;
        end else if (setAlarm) begin
            alarm_d = 1'b1;
        end else if (clear_i) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            tssi_q  <= '0;
            alarm_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            tssi_q  <= tssi_d;
            alarm_q <= alarm_d;
        end
    end

    assign tssi_o  = tssi_q;
    assign alarm_o = alarm_q;

endmodule

// File: rtl/rf_odp_monitor.sv
// RF overdrive-protection monitor: windowed per-channel power sums with
// sticky alarms and a combined PA shutdown request.
module rf_odp_monitor
    import rf_odp_monitor_pkg::*;
#(
    parameter int NUM_CH = rf_odp_monitor_pkg::NUM_CH,
    parameter int PWR_W  = rf_odp_monitor_pkg::PWR_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_valid,
    input  logic [NUM_CH-1:0][PWR_W-1:0]   s_pwr,
    input  logic [TSSI_W-1:0]              rf_overdrive_thresh,
    input  logic [AVG_PER_W-1:0]           rf_overdrive_avg_per,
    input  logic [NUM_CH-1:0]              disable_rf_odp,
    input  logic                           odp_clear,
    output logic [NUM_CH-1:0][TSSI_W-1:0]  rf_overdrive_tssi,
    output logic [NUM_CH-1:0]              odp_alarm,
    output logic                           pa_shutdown
);

    localparam int AccW = PWR_W + AVG_PER_W;

    odpState_e             state_q, state_d;
    logic [AVG_PER_W-1:0]  winLen_q, winLen_d;
    logic [AVG_PER_W-1:0]  count_q, count_d;
    logic [AVG_PER_W-1:0]  countInc;
    logic                  startWin;
    logic                  acceptSample;
    logic                  evalWin;
    logic                  paShutdown_q;

    assign countInc = count_q + AVG_PER_W'(1);

    // The window length is latched only at window start, so register
    // changes mid-window never disturb the window in progress.
    always_comb begin
        state_d      = state_q;
        winLen_d     = winLen_q;
        count_d      = count_q;
        startWin     = 1'b0;
        acceptSample = 1'b0;
        evalWin      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rf_overdrive_avg_per != '0) begin
                    startWin     = 1'b1;
                    acceptSample = s_valid;
                    winLen_d     = rf_overdrive_avg_per;
                    count_d      = AVG_PER_W'(s_valid);
                    state_d      = (s_valid && (rf_overdrive_avg_per == AVG_PER_W'(1))) ? EVAL : ACCUM;
                end
            end
            ACCUM: begin
                if (s_valid) begin
                    acceptSample = 1'b1;
                    count_d      = countInc;
                    if (countInc == winLen_q) begin
                        state_d = EVAL;
                    end
                end
            end
            EVAL: begin
                evalWin = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            winLen_q     <= '0;
            count_q      <= '0;
            paShutdown_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            winLen_q     <= winLen_d;
            count_q      <= count_d;
            paShutdown_q <= |odp_alarm;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : gChan
        rf_odp_chan #(
            .PWR_W (PWR_W),
            .ACC_W (AccW)
        ) uChan (
            .clk       (clk),
            .rst_n     (rst_n),
            .start_i   (startWin),
            .accept_i  (acceptSample),
            .pwr_i     (s_pwr[g]),
            .eval_i    (evalWin),
            .thresh_i  (rf_overdrive_thresh),
            .disable_i (disable_rf_odp[g]),
            .clear_i   (odp_clear),
            .tssi_o    (rf_overdrive_tssi[g]),
            .alarm_o   (odp_alarm[g])
        );
    end

    assign pa_shutdown = paShutdown_q;

endmodule

// File: tb/tb_rf_odp_monitor.sv
// Self-checking bench for rf_odp_monitor: directed window scenarios pinned
// with literal values, then randomized traffic against a behavioural model.
module tb_rf_odp_monitor;

    // A 20-bit lane lets a few-thousand-sample window overflow 32 bits.
    localparam int NUM_CH = 4;
    localparam int PWR_W  = 20;
    localparam longint SAT_MAX = 64'h0000_0000_FFFF_FFFF;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic                          sValid;
    logic [NUM_CH-1:0][PWR_W-1:0]  sPwr;
    logic [31:0]                   thresh;
    logic [20:0]                   avgPer;
    logic [NUM_CH-1:0]             disableOdp;
    logic                          odpClear;
    logic [NUM_CH-1:0][31:0]       tssi;
    logic [NUM_CH-1:0]             alarm;
    logic                          paShutdown;

    always #5 clk = ~clk;

    rf_odp_monitor #(
        .NUM_CH (NUM_CH),
        .PWR_W  (PWR_W)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .s_valid              (sValid),
        .s_pwr                (sPwr),
        .rf_overdrive_thresh  (thresh),
        .rf_overdrive_avg_per (avgPer),
        .disable_rf_odp       (disableOdp),
        .odp_clear            (odpClear),
        .rf_overdrive_tssi    (tssi),
        .odp_alarm            (alarm),
        .pa_shutdown          (paShutdown)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: a window is either open and collecting samples,
    // or has just filled and its result is published on the following
    // cycle (that cycle's sample is lost); otherwise it opens on demand.
    bit     mOpen;
    bit     mGap;
    int     mWinLen;
    int     mCnt;
    longint mSum   [NUM_CH];
    longint mTssi  [NUM_CH];
    bit     mAlarm [NUM_CH];
    bit     mPa;

    task automatic modelReset();
        mOpen   = 1'b0;
        mGap    = 1'b0;
        mWinLen = 0;
        mCnt    = 0;
        mPa     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            mSum[i]   = 0;
            mTssi[i]  = 0;
            mAlarm[i] = 1'b0;
        end
    endtask

    task automatic modelStep();
        bit evalNow;
        bit anyAlarm;
        evalNow  = mGap;
        anyAlarm = 1'b0;
        for (int i = 0; i < NUM_CH; i++) anyAlarm = anyAlarm | mAlarm[i];
        if (mGap) begin
            for (int i = 0; i < NUM_CH; i++) mTssi[i] = (mSum[i] > SAT_MAX) ? SAT_MAX : mSum[i];
            mGap = 1'b0;
        end else if (mOpen) begin
            if (sValid) begin
                for (int i = 0; i < NUM_CH; i++) mSum[i] += longint'(sPwr[i]);
                mCnt++;
                if (mCnt == mWinLen) begin
                    mOpen = 1'b0;
                    mGap  = 1'b1;
                end
            end
        end else if (avgPer != 0) begin
            mWinLen = int'(avgPer);
            mCnt    = 0;
            for (int i = 0; i < NUM_CH; i++) mSum[i] = 0;
            if (sValid) begin
                for (int i = 0; i < NUM_CH; i++) mSum[i] = longint'(sPwr[i]);
                mCnt = 1;
            end
            if (mCnt == mWinLen) mGap = 1'b1;
            else                 mOpen = 1'b1;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (disableOdp[i])                                   mAlarm[i] = 1'b0;
            else if (evalNow && (mTssi[i] >= longint'(thresh)))  mAlarm[i] = 1'b1;
            else if (odpClear)                                   mAlarm[i] = 1'b0;
        end
        mPa = anyAlarm;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            if (errors <= 25)
                $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic compareAll();
        for (int i = 0; i < NUM_CH; i++) begin
            checkOutput($sformatf("tssi[%0d]", i), 64'(tssi[i]), 64'(mTssi[i]));
            checkOutput($sformatf("odp_alarm[%0d]", i), 64'(alarm[i]), 64'(mAlarm[i]));
        end
        checkOutput("pa_shutdown", 64'(paShutdown), 64'(mPa));
    endtask

    // Inputs are driven at the falling edge, sampled by DUT and model at
    // the rising edge, and outputs compared at the next falling edge.
    task automatic applyStimulus(input logic v, input logic clr, input logic [NUM_CH-1:0][PWR_W-1:0] p);
        sValid   = v;
        odpClear = clr;
        sPwr     = p;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        compareAll();
    endtask

    task automatic doReset();
        #1 rst_n = 1'b0;
        modelReset();
        @(negedge clk);
        compareAll();
        rst_n = 1'b1;
    endtask

    function automatic logic [NUM_CH-1:0][PWR_W-1:0] lane0(input int v);
        logic [NUM_CH-1:0][PWR_W-1:0] r;
        r    = '0;
        r[0] = PWR_W'(v);
        return r;
    endfunction

    initial begin
        logic [NUM_CH-1:0][PWR_W-1:0] rp;

        rst_n      = 1'b1;
        sValid     = 1'b0;
        sPwr       = '0;
        thresh     = 32'd1000;
        avgPer     = '0;
        disableOdp = '0;
        odpClear   = 1'b0;
        modelReset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        compareAll();
        checkOutput("reset tssi0", 64'(tssi[0]), 64'd0);
        checkOutput("reset alarm", 64'(alarm), 64'd0);
        checkOutput("reset pa", 64'(paShutdown), 64'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, '0);

        // Four samples of 300 against a 1000 threshold.
        avgPer = 21'd4;
        applyStimulus(1'b0, 1'b0, '0);
        repeat (4) applyStimulus(1'b1, 1'b0, lane0(300));
        avgPer = '0;
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("win4 tssi0", 64'(tssi[0]), 64'd1200);
        checkOutput("win4 alarm0", 64'(alarm[0]), 64'd1);
        checkOutput("win4 pa early", 64'(paShutdown), 64'd0);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("win4 pa", 64'(paShutdown), 64'd1);

        // Same window with channel 0 disabled.
        disableOdp = 4'b0001;
        repeat (2) applyStimulus(1'b0, 1'b0, '0);
        checkOutput("disable clears alarm0", 64'(alarm[0]), 64'd0);
        avgPer = 21'd4;
        applyStimulus(1'b0, 1'b0, '0);
        repeat (4) applyStimulus(1'b1, 1'b0, lane0(301));
        avgPer = '0;
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("disabled tssi0", 64'(tssi[0]), 64'd1204);
        checkOutput("disabled alarm0", 64'(alarm[0]), 64'd0);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("disabled pa", 64'(paShutdown), 64'd0);
        disableOdp = '0;

        // Clear coinciding with a new over-threshold result loses to the set.
        avgPer = 21'd2;
        applyStimulus(1'b0, 1'b0, '0);
        repeat (2) applyStimulus(1'b1, 1'b0, lane0(600));
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("clr-race first alarm0", 64'(alarm[0]), 64'd1);
        repeat (2) applyStimulus(1'b1, 1'b0, lane0(600));
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("clr-race alarm0", 64'(alarm[0]), 64'd1);
        repeat (2) applyStimulus(1'b1, 1'b0, lane0(100));
        avgPer = '0;
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("low window tssi0", 64'(tssi[0]), 64'd200);
        checkOutput("sticky alarm0", 64'(alarm[0]), 64'd1);
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("cleared alarm0", 64'(alarm[0]), 64'd0);

        // Window length change mid-window applies to the next window only.
        avgPer = 21'd4;
        applyStimulus(1'b0, 1'b0, '0);
        repeat (2) applyStimulus(1'b1, 1'b0, lane0(10));
        avgPer = 21'd8;
        repeat (2) applyStimulus(1'b1, 1'b0, lane0(10));
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("len change first tssi0", 64'(tssi[0]), 64'd40);
        applyStimulus(1'b0, 1'b0, '0);
        repeat (8) applyStimulus(1'b1, 1'b0, lane0(10));
        avgPer = '0;
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("len change second tssi0", 64'(tssi[0]), 64'd80);

        // Reset after the third sample discards the partial window.
        avgPer = 21'd4;
        applyStimulus(1'b0, 1'b0, '0);
        repeat (3) applyStimulus(1'b1, 1'b0, lane0(2000));
        avgPer = '0;
        doReset();
        repeat (3) applyStimulus(1'b0, 1'b0, '0);
        checkOutput("mid reset tssi0", 64'(tssi[0]), 64'd0);
        checkOutput("mid reset alarm", 64'(alarm), 64'd0);
        checkOutput("mid reset pa", 64'(paShutdown), 64'd0);

        // Continuous valid with a 3-sample window: the publish cycle drops one.
        avgPer = 21'd3;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b0, lane0(k));
            if (k == 4) checkOutput("drop first tssi0", 64'(tssi[0]), 64'd6);
            if (k == 8) checkOutput("drop second tssi0", 64'(tssi[0]), 64'd18);
        end
        avgPer = '0;
        repeat (2) applyStimulus(1'b0, 1'b0, '0);

        // Saturation: all-ones lanes over a long window hit the 32-bit ceiling.
        thresh = 32'hFFFF_FFFF;
        avgPer = 21'd5000;
        applyStimulus(1'b0, 1'b0, '0);
        repeat (5000) applyStimulus(1'b1, 1'b0, '1);
        avgPer = '0;
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("sat tssi0", 64'(tssi[0]), 64'hFFFF_FFFF);
        checkOutput("sat tssi3", 64'(tssi[3]), 64'hFFFF_FFFF);
        checkOutput("sat alarm", 64'(alarm), 64'hF);
        applyStimulus(1'b0, 1'b1, '0);

        // Randomized traffic checked every cycle against the model.
        thresh = 32'd5000;
        avgPer = 21'd3;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 99) < 3)   avgPer = 21'($urandom_range(0, 9));
            if ($urandom_range(0, 99) < 2)   thresh = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20000)) : 32'($urandom);
            if ($urandom_range(0, 99) < 2)   disableOdp = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0;
            if ($urandom_range(0, 499) == 0) doReset();
            for (int c = 0; c < NUM_CH; c++)
                rp[c] = ($urandom_range(0, 3) == 0) ? PWR_W'($urandom) : PWR_W'($urandom_range(0, 3000));
            applyStimulus($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 4, rp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
